// File: rtl/div_scheduler.sv
// Round-robin front end for a shared combinational signed divider: two requesters,
// operands held for a settle window, registered result returned per owner.
module div_scheduler #(
  parameter int XLEN          = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b0,
  input  logic [XLEN-1:0] req_b1,
  input  logic [1:0]      req_op,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_dbz,
  output logic [XLEN-1:0] div_oper_a,
  output logic [XLEN-1:0] div_oper_b,
  output logic            div_operation,
  output logic            div_enable,
  input  logic [XLEN-1:0] div_result,
  output logic [1:0]      state_dbg
);

  // Handshakes: a request i transfers on a rising edge with req_valid[i] && req_ready[i];
  // a response transfers on an edge with rsp_valid[owner] && rsp_ready[owner]. Valid must
  // be held until the transfer; the side presenting valid keeps its payload stable meanwhile.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t          state, state_next;
  logic            owner;
  logic            last_grant;
  logic [XLEN-1:0] opa, opb;
  logic            op;
  logic [3:0]      cnt;
  logic [XLEN-1:0] result;
  logic            dbz;

  logic            grant;
  logic            accept;
  logic            busy;

  // With contention the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign accept    = (state == IDLE) && req_valid[grant];
  assign req_ready = (accept && rst_n) ? {grant, ~grant} : 2'b00;
  assign busy      = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      opa        <= '0;
      opb        <= '0;
      op         <= 1'b0;
      cnt        <= 4'd0;
      result     <= '0;
      dbz        <= 1'b0;
    end else begin
      if (accept) begin
        opa        <= grant ? req_a1 : req_a0;
        opb        <= grant ? req_b1 : req_b0;
        op         <= req_op[grant];
        owner      <= grant;
        last_grant <= grant;
        cnt        <= CNT_INIT;
      end
      if (busy) begin
        if (cnt == 4'd0) begin
          result <= div_result;
          dbz    <= (opb == '0);
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Operands are zeroed outside BUSY so the divider idles at a known 0 output.
  assign div_enable    = busy;
  assign div_oper_a    = busy ? opa : '0;
  assign div_oper_b    = busy ? opb : '0;
  assign div_operation = busy ? op : 1'b0;

  assign rsp_valid = (state == RESP) ? {owner, ~owner} : 2'b00;
  assign rsp_data  = result;
  assign rsp_dbz   = dbz;
  assign state_dbg = state;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural stand-in for the shared
// combinational divider; expected results are hand-computed constants.
module tb_div_scheduler;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]      req_op;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_dbz;
  logic [XLEN-1:0] div_oper_a, div_oper_b;
  logic            div_operation;
  logic            div_enable;
  logic [XLEN-1:0] div_result;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  div_scheduler #(.XLEN(XLEN), .SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (req_a0),
    .req_a1       (req_a1),
    .req_b0       (req_b0),
    .req_b1       (req_b1),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_dbz      (rsp_dbz),
    .div_oper_a   (div_oper_a),
    .div_oper_b   (div_oper_b),
    .div_operation(div_operation),
    .div_enable   (div_enable),
    .div_result   (div_result),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational signed divider: truncating quotient/remainder, 0 when b == 0.
  always_comb begin
    div_result = '0;
    if (div_enable && div_oper_b != '0) begin
      if (div_operation) div_result = $signed(div_oper_a) / $signed(div_oper_b);
      else               div_result = $signed(div_oper_a) % $signed(div_oper_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on a port, count enable cycles, check the response, then retire it.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic is_div, input logic [31:0] exp_data, input logic exp_dbz);
    int en_cnt;
    @(negedge clk);
    if (port == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_op[port]    = is_div;
    req_valid[port] = 1'b1;
    #1;
    chk("req_ready_idle", {30'd0, req_ready}, (port == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    #1;
    chk("req_ready_busy", {30'd0, req_ready}, 32'd0);
    chk("state_busy", {30'd0, state_dbg}, 32'd1);
    req_valid[port] = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid != 2'b00) break;
      if (div_enable) en_cnt++;
      @(negedge clk);
    end
    chk("enable_cycles", en_cnt, 32'd4);
    chk("rsp_valid", {30'd0, rsp_valid}, (port == 0) ? 32'd1 : 32'd2);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, exp_dbz});
    chk("div_enable_resp", {31'd0, div_enable}, 32'd0);
    rsp_ready[port] = 1'b1;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("state_idle_after", {30'd0, state_dbg}, 32'd0);
    chk("rsp_valid_after", {30'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          grant_seen;
    int          found;
    logic [31:0] exp_g;
    logic [31:0] held_data;

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_op    = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_div_enable", {31'd0, div_enable}, 32'd0);
    chk("rst_oper_a", div_oper_a, 32'd0);
    chk("rst_oper_b", div_oper_b, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Single DIV and REM/DIV on the accelerator port, including a negative quotient.
    run_op(0, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
    run_op(1, 32'd100, 32'd7, 1'b0, 32'd2, 1'b0);
    run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);

    // Divide by zero followed by a normal divide clears the flag.
    run_op(0, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1);
    run_op(0, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0);

    // Continuous contention after reset alternates 0,1,0,1.
    do_reset();
    @(negedge clk);
    req_a0 = 32'd20; req_b0 = 32'd4; req_op[0] = 1'b1;
    req_a1 = 32'd21; req_b1 = 32'd4; req_op[1] = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 32'd1 : 32'd2;
      grant_seen = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (req_ready != 2'b00) begin grant_seen = {30'd0, req_ready}; break; end
        @(negedge clk);
      end
      chk("rr_grant", grant_seen, exp_g);
      found = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rsp_valid != 2'b00) begin found = 1; break; end
      end
      chk("rr_rsp_valid", {30'd0, rsp_valid}, exp_g);
      chk("rr_rsp_data", rsp_data, (k % 2 == 0) ? 32'd5 : 32'd1);
      chk("rr_found", found, 32'd1);
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Backpressure: response held 20 cycles while requester 0 waits.
    @(negedge clk);
    req_a1 = 32'd50; req_b1 = 32'd5; req_op[1] = 1'b1;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid != 2'b00) break;
      @(negedge clk);
    end
    req_a0 = 32'd1; req_b0 = 32'd1;
    req_valid = 2'b01;
    held_data = 32'd10;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      chk("bp_rsp_data", rsp_data, held_data);
      chk("bp_rsp_dbz", {31'd0, rsp_dbz}, 32'd0);
      chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
      if (i == 10) rsp_ready = 2'b01;
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("bp_state_idle", {30'd0, state_dbg}, 32'd0);
    chk("bp_rsp_valid_low", {30'd0, rsp_valid}, 32'd0);
    chk("bp_req_ready_next", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;

    // Reset during the second BUSY cycle discards the operation and last_grant.
    @(negedge clk);
    req_a0 = 32'd100; req_b0 = 32'd7; req_op[0] = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    chk("abort_busy1", {30'd0, state_dbg}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_enable", {31'd0, div_enable}, 32'd0);
    chk("abort_state", {30'd0, state_dbg}, 32'd0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) rst_n = 1'b1;
      if (rsp_valid != 2'b00) found = 1;
      @(negedge clk);
    end
    chk("abort_no_rsp", found, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("abort_first_grant", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
